// File: rtl/dvfs_pkg.sv
// Shared types and helpers for the DVFS voltage/frequency sequencer.
package dvfs_pkg;

    typedef logic [1:0] level_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_V_WAIT = 2'd1,
        ST_F_WAIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam level_t LVL_MIN = 2'd0;
    localparam level_t LVL_MAX = 2'd3;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dvfs_timer.sv
// Loadable saturating down-counter with zero/one flags; load wins over decrement.
module dvfs_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/dvfs_sequencer.sv
// Orders regulator and PLL level changes so voltage_level >= frequency_level on every cycle,
// with settle, lock, timeout and post-completion dwell handling.
module dvfs_sequencer
    import dvfs_pkg::*;
#(
    parameter int V_SETTLE_CYCLES  = 64,
    parameter int F_LOCK_CYCLES    = 32,
    parameter int PLL_TIMEOUT      = 1024,
    parameter int MIN_DWELL_CYCLES = 256
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_valid,
    input  level_t req_level,
    input  logic   pll_lock,
    output level_t voltage_level,
    output level_t frequency_level,
    output logic   busy,
    output logic   done,
    output logic   fault
);

    localparam int T_MAX = (V_SETTLE_CYCLES > F_LOCK_CYCLES) ? V_SETTLE_CYCLES : F_LOCK_CYCLES;
    localparam int TW    = cnt_width(T_MAX);
    localparam int DW    = cnt_width(MIN_DWELL_CYCLES);
    localparam int OW    = cnt_width(PLL_TIMEOUT);

    state_t  state_q, state_d;
    dir_t    dir_q, dir_d;
    level_t  target_q, target_d;
    level_t  v_q, v_d;
    level_t  f_q, f_d;
    logic    done_q, done_d;
    logic    fault_q, fault_d;
    logic [OW-1:0] to_q, to_d;

    logic          t_load, t_dec, t_zero, t_one;
    logic [TW-1:0] t_val;
    logic          d_load, d_dec, d_zero;

    dvfs_timer #(.WIDTH(TW)) u_step_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (t_load),
        .load_val_i (t_val),
        .dec_i      (t_dec),
        .zero_o     (t_zero),
        .one_o      (t_one)
    );

    dvfs_timer #(.WIDTH(DW)) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (d_load),
        .load_val_i (DW'(MIN_DWELL_CYCLES)),
        .dec_i      (d_dec),
        .zero_o     (d_zero),
        .one_o      ()
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        target_d = target_q;
        v_d      = v_q;
        f_d      = f_q;
        done_d   = 1'b0;
        fault_d  = fault_q;
        to_d     = '0;
        t_load   = 1'b0;
        t_val    = '0;
        t_dec    = 1'b0;
        d_load   = 1'b0;
        d_dec    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                d_dec = 1'b1;
                if (req_valid && d_zero && (req_level != v_q)) begin
                    target_d = req_level;
                    t_load   = 1'b1;
                    if (req_level > v_q) begin
                        dir_d   = DIR_UP;
                        v_d     = req_level;
                        t_val   = TW'(V_SETTLE_CYCLES);
                        state_d = ST_V_WAIT;
                    end else begin
                        dir_d   = DIR_DOWN;
                        f_d     = req_level;
                        t_val   = TW'(F_LOCK_CYCLES);
                        state_d = ST_F_WAIT;
                    end
                end
            end
            ST_V_WAIT: begin
                if (t_one) begin
                    if (dir_q == DIR_UP) begin
                        f_d     = target_q;
                        t_load  = 1'b1;
                        t_val   = TW'(F_LOCK_CYCLES);
                        state_d = ST_F_WAIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_F_WAIT: begin
                if (!t_zero) begin
                    t_dec = 1'b1;
                end else if (pll_lock) begin
                    if (dir_q == DIR_UP) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        v_d     = target_q;
                        t_load  = 1'b1;
                        t_val   = TW'(V_SETTLE_CYCLES);
                        state_d = ST_V_WAIT;
                    end
                end else if (to_q == OW'(PLL_TIMEOUT - 1)) begin
                    // Abandon without touching voltage: on a DOWN step V is still the higher level.
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + OW'(1);
                end
            end
            ST_DONE: begin
                d_load  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_UP;
            target_q <= LVL_MIN;
            v_q      <= LVL_MIN;
            f_q      <= LVL_MIN;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            target_q <= target_d;
            v_q      <= v_d;
            f_q      <= f_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            to_q     <= to_d;
        end
    end

    assign voltage_level   = v_q;
    assign frequency_level = f_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign fault           = fault_q;

endmodule
